// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared state encoding, beat-count helper and window defaults for the camera capture block
package cam_pkg;

    // Capture FSM states
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_LINE = 2'd1,
        ST_ACTIVE    = 2'd2,
        ST_LINE_END  = 2'd3
    } cam_state_e;

    // Window registers come out of reset fully open; a VSYNC edge reloads them.
    localparam logic [31:0] DEF_WIN_START = 32'h0000_0000;
    localparam logic [31:0] DEF_WIN_END   = 32'hFFFF_FFFF;

    // Number of camera beats that make one packed pixel.
    function automatic int beats_of(input int pixel_width, input int data_width);
        return pixel_width / data_width;
    endfunction

endpackage

// File: rtl/cam_pixel_capture_if.sv
// rtl/cam_pixel_capture_if.sv - camera input stream and pixel write bus of the capture block
// Ports (members):
//   CAM_DATA/CAM_VSYNC/CAM_HREF  camera beat, frame sync, line valid (source -> capture)
//   PIX_DATA/PIX_VALID/ADDRA     packed pixel, write strobe, write address (capture -> buffer)
interface cam_pixel_capture_if #(
    parameter int CAM_DATA_WIDTH = 8,
    parameter int PIXEL_WIDTH    = 16,
    parameter int ADDR_WIDTH     = 10
);
    logic [CAM_DATA_WIDTH-1:0] CAM_DATA;
    logic                      CAM_VSYNC;
    logic                      CAM_HREF;
    logic [PIXEL_WIDTH-1:0]    PIX_DATA;
    logic                      PIX_VALID;
    logic [ADDR_WIDTH-1:0]     ADDRA;

    modport master (
        output CAM_DATA, CAM_VSYNC, CAM_HREF,
        input  PIX_DATA, PIX_VALID, ADDRA
    );

    modport slave (
        input  CAM_DATA, CAM_VSYNC, CAM_HREF,
        output PIX_DATA, PIX_VALID, ADDRA
    );
endinterface

// File: rtl/cam_beat_packer.sv
// rtl/cam_beat_packer.sv - packs camera beats MSB-first into pixels
// Ports:
//   clk, resetn      clock, synchronous active-low reset
//   beat_en          a valid beat is present on data this cycle
//   data             camera beat
//   pixel_done       this beat completes a pixel (combinational)
//   pixel            completed pixel word, valid with pixel_done
//   partial_drop     beat stream stopped with a partially built pixel
module cam_beat_packer
    import cam_pkg::*;
#(
    parameter int CAM_DATA_WIDTH = 8,
    parameter int PIXEL_WIDTH    = 16
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      beat_en,
    input  logic [CAM_DATA_WIDTH-1:0] data,
    output logic                      pixel_done,
    output logic [PIXEL_WIDTH-1:0]    pixel,
    output logic                      partial_drop
);
    localparam int BEATS = beats_of(PIXEL_WIDTH, CAM_DATA_WIDTH);
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SW    = (BEATS > 1) ? PIXEL_WIDTH - CAM_DATA_WIDTH : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    logic [CW-1:0] beat_cnt;
    logic [SW-1:0] shift;

    // The current beat is the least significant part of the word; earlier beats sit above it.
    assign pixel        = PIXEL_WIDTH'({shift, data});
    assign pixel_done   = beat_en && (beat_cnt == LAST);
    assign partial_drop = !beat_en && (beat_cnt != '0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            beat_cnt <= '0;
            shift    <= '0;
        end else if (beat_en) begin
            shift    <= pixel[SW-1:0];
            beat_cnt <= pixel_done ? '0 : beat_cnt + CW'(1);
        end else begin
            beat_cnt <= '0;
        end
    end
endmodule

// File: rtl/cam_pixel_capture.sv
// rtl/cam_pixel_capture.sv - DVP camera capture with crop window, 2:1 decimation and buffer addressing
// Ports:
//   CAM_CLK, RESET                  clock, synchronous active-low reset
//   bus (slave)                     camera beats in, pixel writes (PIX_DATA/PIX_VALID/ADDRA) out
//   X_START/X_END, Y_START/Y_END    inclusive crop window, latched at each frame start
//   DECIM_EN                        keep even columns and even lines only
//   LINE_MODE                       1 = address restarts every line, 0 = every frame
//   LINE_DONE, FRAME_DONE           one-cycle status pulses
//   ERR_PARTIAL, ERR_OVF            sticky per-frame error flags
module cam_pixel_capture
    import cam_pkg::*;
#(
    parameter int CAM_DATA_WIDTH = 8,
    parameter int PIXEL_WIDTH    = 16,
    parameter int ADDR_WIDTH     = 10,
    parameter int CNT_WIDTH      = 12
) (
    input  logic                 CAM_CLK,
    input  logic                 RESET,
    cam_pixel_capture_if.slave   bus,
    input  logic [CNT_WIDTH-1:0] X_START,
    input  logic [CNT_WIDTH-1:0] X_END,
    input  logic [CNT_WIDTH-1:0] Y_START,
    input  logic [CNT_WIDTH-1:0] Y_END,
    input  logic                 DECIM_EN,
    input  logic                 LINE_MODE,
    output logic                 LINE_DONE,
    output logic                 FRAME_DONE,
    output logic                 ERR_PARTIAL,
    output logic                 ERR_OVF
);
    logic [CAM_DATA_WIDTH-1:0] data_r;
    logic                      vsync_r, vsync_prev, href_r;
    cam_state_e                state;
    logic [CNT_WIDTH-1:0]      x_cnt, y_cnt, x_cur;
    logic [CNT_WIDTH-1:0]      x_start_r, x_end_r, y_start_r, y_end_r;
    logic                      decim_r;
    logic                      line_kept;
    logic [ADDR_WIDTH-1:0]     wr_addr;
    logic                      vsync_rise, beat_en, keep;
    logic                      pixel_done, partial_drop;
    logic [PIXEL_WIDTH-1:0]    pixel;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign vsync_rise = vsync_r && !vsync_prev;
    // The beat that moves WAIT_LINE to ACTIVE is already the first beat of the line.
    assign beat_en    = href_r && !vsync_rise &&
                        ((state == ST_WAIT_LINE) || (state == ST_ACTIVE));
    assign x_cur      = (state == ST_ACTIVE) ? x_cnt : '0;
    assign keep       = (x_cur >= x_start_r) && (x_cur <= x_end_r) &&
                        (y_cnt >= y_start_r) && (y_cnt <= y_end_r) &&
                        (!decim_r || (!x_cur[0] && !y_cnt[0]));

    cam_beat_packer #(
        .CAM_DATA_WIDTH (CAM_DATA_WIDTH),
        .PIXEL_WIDTH    (PIXEL_WIDTH)
    ) u_packer (
        .clk          (CAM_CLK),
        .resetn       (RESET),
        .beat_en      (beat_en),
        .data         (data_r),
        .pixel_done   (pixel_done),
        .pixel        (pixel),
        .partial_drop (partial_drop)
    );

    always_ff @(posedge CAM_CLK) begin
        if (!RESET) begin
            data_r        <= '0;
            vsync_r       <= 1'b0;
            vsync_prev    <= 1'b0;
            href_r        <= 1'b0;
            state         <= ST_IDLE;
            x_cnt         <= '0;
            y_cnt         <= '0;
            x_start_r     <= DEF_WIN_START[CNT_WIDTH-1:0];
            x_end_r       <= DEF_WIN_END[CNT_WIDTH-1:0];
            y_start_r     <= DEF_WIN_START[CNT_WIDTH-1:0];
            y_end_r       <= DEF_WIN_END[CNT_WIDTH-1:0];
            decim_r       <= 1'b0;
            line_kept     <= 1'b0;
            wr_addr       <= '0;
            bus.PIX_DATA  <= '0;
            bus.PIX_VALID <= 1'b0;
            bus.ADDRA     <= '0;
            LINE_DONE     <= 1'b0;
            FRAME_DONE    <= 1'b0;
            ERR_PARTIAL   <= 1'b0;
            ERR_OVF       <= 1'b0;
        end else begin
            data_r        <= bus.CAM_DATA;
            vsync_r       <= bus.CAM_VSYNC;
            href_r        <= bus.CAM_HREF;
            vsync_prev    <= vsync_r;
            bus.PIX_VALID <= 1'b0;
            LINE_DONE     <= 1'b0;
            FRAME_DONE    <= 1'b0;

            if (vsync_rise) begin
                // A VSYNC edge outside IDLE closes the running frame; any partial
                // pixel is discarded and the new frame's error clear takes priority.
                FRAME_DONE  <= (state != ST_IDLE);
                state       <= ST_WAIT_LINE;
                x_cnt       <= '0;
                y_cnt       <= '0;
                line_kept   <= 1'b0;
                wr_addr     <= '0;
                bus.ADDRA   <= '0;
                ERR_PARTIAL <= 1'b0;
                ERR_OVF     <= 1'b0;
                x_start_r   <= X_START;
                x_end_r     <= X_END;
                y_start_r   <= Y_START;
                y_end_r     <= Y_END;
                decim_r     <= DECIM_EN;
            end else begin
                case (state)
                    ST_WAIT_LINE: begin
                        if (href_r) begin
                            state     <= ST_ACTIVE;
                            x_cnt     <= '0;
                            line_kept <= 1'b0;
                        end
                    end
                    ST_ACTIVE: begin
                        if (!href_r) begin
                            state <= ST_LINE_END;
                            if (partial_drop) ERR_PARTIAL <= 1'b1;
                        end
                    end
                    ST_LINE_END: begin
                        state     <= ST_WAIT_LINE;
                        y_cnt     <= sat_inc(y_cnt);
                        LINE_DONE <= line_kept;
                        if (LINE_MODE) begin
                            wr_addr   <= '0;
                            bus.ADDRA <= '0;
                        end
                    end
                    default: ;
                endcase

                if (pixel_done) begin
                    x_cnt <= sat_inc(x_cur);
                    if (keep) begin
                        bus.PIX_VALID <= 1'b1;
                        bus.PIX_DATA  <= pixel;
                        bus.ADDRA     <= wr_addr;
                        wr_addr       <= wr_addr + ADDR_WIDTH'(1);
                        line_kept     <= 1'b1;
                        if ((&wr_addr) && !LINE_MODE) ERR_OVF <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_cam_pixel_capture.sv
// tb/tb_cam_pixel_capture.sv - self-checking bench for cam_pixel_capture
module tb_cam_pixel_capture;
    localparam int DW = 8, PW = 16, AW = 4, CW = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn;
    logic [CW-1:0] x_start, x_end, y_start, y_end;
    logic          decim_en, line_mode;
    logic          line_done, frame_done, err_partial, err_ovf;

    cam_pixel_capture_if #(.CAM_DATA_WIDTH(DW), .PIXEL_WIDTH(PW), .ADDR_WIDTH(AW)) bus ();

    cam_pixel_capture #(
        .CAM_DATA_WIDTH(DW), .PIXEL_WIDTH(PW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
    ) dut (
        .CAM_CLK(clk), .RESET(resetn), .bus(bus),
        .X_START(x_start), .X_END(x_end), .Y_START(y_start), .Y_END(y_end),
        .DECIM_EN(decim_en), .LINE_MODE(line_mode),
        .LINE_DONE(line_done), .FRAME_DONE(frame_done),
        .ERR_PARTIAL(err_partial), .ERR_OVF(err_ovf)
    );

    typedef struct packed {
        logic [PW-1:0] d;
        logic [AW-1:0] a;
    } wr_t;

    typedef struct {
        int xs, xe, ys, ye, decim, lm, pattern, tabled, nb, nl;
        int exp_wr, exp_ld, exp_ovf, exp_part;
    } vec_t;

    wr_t        wq[$];
    int         ld_cnt = 0, fd_cnt = 0;
    int         n_checks = 0, n_err = 0;
    logic [7:0] beats [0:7][0:31];

    always @(negedge clk) begin
        if (bus.PIX_VALID === 1'b1) wq.push_back({bus.PIX_DATA, bus.ADDRA});
        if (line_done === 1'b1) ld_cnt++;
        if (frame_done === 1'b1) fd_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic vsync_pulse();
        bus.CAM_VSYNC = 1'b1;
        tick(2);
        bus.CAM_VSYNC = 1'b0;
        tick(6);
    endtask

    task automatic drive_line(input int y, input int nb);
        for (int i = 0; i < nb; i++) begin
            bus.CAM_HREF = 1'b1;
            bus.CAM_DATA = beats[y][i];
            tick(1);
        end
        bus.CAM_HREF = 1'b0;
        bus.CAM_DATA = 8'($urandom);
        tick(5);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        wr_t exp_q[$];
        int  wb, lb, fb, nw, addr, kept, ld, ovf, part, lk, keep;
        int  e_wr, e_ld, e_ovf, e_part;

        x_start = CW'(v.xs); x_end = CW'(v.xe);
        y_start = CW'(v.ys); y_end = CW'(v.ye);
        decim_en = v.decim[0]; line_mode = v.lm[0];
        vsync_pulse();
        wb = wq.size(); lb = ld_cnt;
        // Window is held from the frame start; later port changes must not matter.
        x_start = CW'($urandom); x_end = CW'($urandom);
        y_start = CW'($urandom); y_end = CW'($urandom);
        decim_en = 1'($urandom);

        for (int y = 0; y < v.nl; y++)
            for (int i = 0; i < v.nb; i++)
                beats[y][i] = v.pattern != 0 ? 8'(161 + 17 * (y * v.nb + i)) : 8'($urandom);

        // Reference: walk every complete pixel of every line and apply the window rules.
        addr = 0; kept = 0; ld = 0; ovf = 0; part = 0;
        for (int y = 0; y < v.nl; y++) begin
            lk = 0;
            if (v.lm != 0) addr = 0;
            for (int p = 0; p < v.nb / 2; p++) begin
                keep = (p >= v.xs && p <= v.xe && y >= v.ys && y <= v.ye &&
                        (v.decim == 0 || (p % 2 == 0 && y % 2 == 0))) ? 1 : 0;
                if (keep != 0) begin
                    exp_q.push_back({beats[y][2*p], beats[y][2*p+1], AW'(addr)});
                    addr = (addr + 1) % (1 << AW);
                    kept++;
                    lk = 1;
                end
            end
            if (v.nb % 2 != 0) part = 1;
            ld += lk;
        end
        ovf = (v.lm == 0 && kept >= (1 << AW)) ? 1 : 0;

        e_wr   = v.tabled != 0 ? v.exp_wr   : exp_q.size();
        e_ld   = v.tabled != 0 ? v.exp_ld   : ld;
        e_ovf  = v.tabled != 0 ? v.exp_ovf  : ovf;
        e_part = v.tabled != 0 ? v.exp_part : part;

        for (int y = 0; y < v.nl; y++) drive_line(y, v.nb);
        tick(4);
        check({tag, " err_ovf"}, 32'(err_ovf), 32'(e_ovf));
        check({tag, " err_partial"}, 32'(err_partial), 32'(e_part));

        fb = fd_cnt;
        vsync_pulse();
        check({tag, " frame_done pulses"}, 32'(fd_cnt - fb), 32'd1);
        check({tag, " err_ovf after vsync"}, 32'(err_ovf), 32'd0);
        check({tag, " err_partial after vsync"}, 32'(err_partial), 32'd0);

        nw = wq.size() - wb;
        check({tag, " write count"}, 32'(nw), 32'(e_wr));
        check({tag, " line_done pulses"}, 32'(ld_cnt - lb), 32'(e_ld));
        for (int i = 0; i < nw && i < exp_q.size(); i++) begin
            check($sformatf("%s pix_data[%0d]", tag, i), 32'(wq[wb+i].d), 32'(exp_q[i].d));
            check($sformatf("%s addra[%0d]", tag, i), 32'(wq[wb+i].a), 32'(exp_q[i].a));
        end
        if (v.pattern != 0 && nw >= 2) begin
            check({tag, " first pixel"}, 32'(wq[wb].d), 32'h0000_A1B2);
            check({tag, " second pixel"}, 32'(wq[wb+1].d), 32'h0000_C3D4);
        end
    endtask

    vec_t tbl[7];
    vec_t rv;
    int   wb, fb;

    initial begin
        //          xs xe ys ye dec lm pat tab nb nl  wr ld ovf part
        tbl[0] = '{0, 3, 0, 1, 0, 0, 1, 1,  8, 2,  8, 2, 0, 0};
        tbl[1] = '{2, 5, 0, 3, 1, 0, 0, 1, 16, 4,  4, 2, 0, 0};
        tbl[2] = '{1, 4, 0, 1, 0, 1, 0, 1, 12, 2,  8, 2, 0, 0};
        tbl[3] = '{0, 9, 0, 1, 0, 0, 0, 1, 20, 2, 20, 2, 1, 0};
        tbl[4] = '{5, 2, 0, 3, 0, 0, 0, 1,  8, 3,  0, 0, 0, 0};
        tbl[5] = '{0, 3, 0, 0, 0, 0, 0, 1,  3, 1,  1, 1, 0, 1};
        tbl[6] = '{0, 15, 1, 2, 0, 0, 0, 1, 4, 4,  4, 2, 0, 0};

        resetn = 1'b0;
        bus.CAM_DATA = '0; bus.CAM_VSYNC = 1'b0; bus.CAM_HREF = 1'b0;
        x_start = '0; x_end = '0; y_start = '0; y_end = '0;
        decim_en = 1'b0; line_mode = 1'b0;
        tick(3);
        check("reset pix_valid", 32'(bus.PIX_VALID), 32'd0);
        check("reset pix_data", 32'(bus.PIX_DATA), 32'd0);
        check("reset addra", 32'(bus.ADDRA), 32'd0);
        check("reset line_done", 32'(line_done), 32'd0);
        check("reset frame_done", 32'(frame_done), 32'd0);
        check("reset errors", {30'd0, err_partial, err_ovf}, 32'd0);
        resetn = 1'b1;
        tick(2);

        for (int t = 0; t < 7; t++) run_vec(tbl[t], $sformatf("vec%0d", t));

        for (int r = 0; r < 6; r++) begin
            rv = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
            rv.xs = $urandom_range(0, 9); rv.xe = $urandom_range(0, 9);
            rv.ys = $urandom_range(0, 3); rv.ye = $urandom_range(0, 4);
            rv.decim = $urandom_range(0, 1); rv.lm = $urandom_range(0, 1);
            rv.nb = $urandom_range(2, 24); rv.nl = $urandom_range(1, 5);
            run_vec(rv, $sformatf("rnd%0d", r));
        end

        // Reset pulse in the middle of a line, then a fresh frame.
        x_start = '0; x_end = 12'd15; y_start = '0; y_end = 12'd7;
        decim_en = 1'b0; line_mode = 1'b0;
        vsync_pulse();
        bus.CAM_HREF = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.CAM_DATA = 8'($urandom);
            tick(1);
        end
        resetn = 1'b0;
        tick(1);
        resetn = 1'b1;
        check("midline reset pix_valid", 32'(bus.PIX_VALID), 32'd0);
        check("midline reset addra", 32'(bus.ADDRA), 32'd0);
        check("midline reset errors", {30'd0, err_partial, err_ovf}, 32'd0);
        wb = wq.size(); fb = fd_cnt;
        for (int i = 0; i < 3; i++) begin
            bus.CAM_DATA = 8'($urandom);
            tick(1);
        end
        bus.CAM_HREF = 1'b0;
        tick(5);
        for (int i = 0; i < 4; i++) beats[0][i] = 8'($urandom);
        drive_line(0, 4);
        check("no writes before vsync", 32'(wq.size() - wb), 32'd0);
        vsync_pulse();
        check("no frame_done leaving idle", 32'(fd_cnt - fb), 32'd0);
        beats[0][0] = 8'h12; beats[0][1] = 8'h34; beats[0][2] = 8'h56; beats[0][3] = 8'h78;
        drive_line(0, 4);
        check("post-reset write count", 32'(wq.size() - wb), 32'd2);
        if (wq.size() - wb >= 2) begin
            check("post-reset pixel0", {16'd0, wq[wb].d, 12'd0, wq[wb].a}, {16'd0, 16'h1234, 12'd0, 4'd0});
            check("post-reset pixel1", {16'd0, wq[wb+1].d, 12'd0, wq[wb+1].a}, {16'd0, 16'h5678, 12'd0, 4'd1});
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
